mcd_dac_i2s_tx: RTL
===================

Name: mcd_dac_i2s_tx

Overview:
- Transmit end of the DacBus audio path; consumes the stereo PCM/CDDA mix that mcd_core produces and drives the external audio DAC serially in I2S format.
- Sits in megacd top-level glue between mcd_core's dac output and the board DAC pins.
- Decouples the core's sample strobe from the fixed serial frame rate through a one-frame holding register.
- Counts overrun and underrun events for diagnostics.

Parameters:
- BCK_DIV, 16: clk cycles per BCK half-period. Frame = 64*BCK_DIV clk; 1024 clk at default (≈48.8 kHz at 50 MHz).
- CNT_W, 8: width of the saturating diagnostic counters.

Ports:
- clk  in  1  system clock (mai.clk domain).
- map_rst  in  1  synchronous, active-high reset.
- snd_l  in  16  left sample, two's complement, valid with snd_vld.
- snd_r  in  16  right sample, two's complement, valid with snd_vld.
- snd_vld  in  1  one-clk strobe: new stereo sample available.
- mute  in  1  when high, frames are loaded with zeros.
- i2s_bck  out  1  bit clock.
- i2s_lrck  out  1  word select (0 = left).
- i2s_dat  out  1  serial data, MSB first.
- frame_req  out  1  one-clk pulse when a frame is loaded; requests the next sample.
- urun_cnt  out  CNT_W  saturating count of frames loaded without a fresh sample.
- orun_cnt  out  CNT_W  saturating count of samples overwritten before use.

Behaviour:
- Reset: all outputs 0; div_cnt=0, slot=0, shift reg sr=0, pend_l/pend_r=0, pend_full=0.
- Divider:
  - div_cnt counts 0..BCK_DIV-1.
  - At terminal count it wraps to 0 and i2s_bck toggles.
  - A "falling event" is a terminal count while i2s_bck=1.
- Slots: a 5-bit slot counter advances on every falling event, 0..31 with wrap. The first falling event after reset is slot 0.
- On each falling event for slot s, all updates are registered the same clk:
  - i2s_lrck <= (s >= 16).
  - i2s_dat <= sr[31].
  - s != 0: sr <= sr << 1.
  - s == 0: sr <= mute ? 0 : {pend_l, pend_r}. Then pend_full <= 0 and frame_req pulses for 1 clk.
  - If pend_full was 0 at the s == 0 load, the previous pend is reloaded (sample repeat) and urun_cnt increments.
- Resulting timing (standard I2S, 1-BCK delay):
  - slot 0: LRCK falls; data = prior R[0].
  - slots 1..16: L[15..0].
  - slot 16: LRCK rises.
  - slots 17..31: R[15..1].
  - next slot 0: R[0].
- Holding register:
  - snd_vld: pend_l/pend_r <= snd_l/snd_r, pend_full <= 1.
  - snd_vld while pend_full=1 and no load this clk: overwrite; orun_cnt increments.
- Simultaneous snd_vld and slot-0 load in the same clk:
  - The load uses the old pend contents.
  - The new sample is stored and pend_full stays 1.
  - No overrun is counted.
  - urun_cnt is judged on the old pend_full.
- Counters saturate at all-ones. They are cleared only by map_rst.
- mute is sampled only at slot 0. A frame in flight is never truncated.
- Reset mid-frame: everything returns to reset state on the next clk, including LRCK/BCK low. Serialisation restarts at slot 0 with no partial frame emitted.
- Latency: a sample strobed at least 1 clk before a slot-0 load appears on i2s_dat starting 2*BCK_DIV clk after that load (slot 1).

Decomposition:
- Shared mapper package:
  - DAC_BITS = 16 and FRAME_SLOTS = 32 constants.
  - Sample struct {snd_l, snd_r} for DacBus.
- Sub-module mcd_dac_bck_gen: divider + slot counter. Outputs falling event, slot index, bck.
- Top of the block holds the holding register, shift register and counters.

Test Plan:
- Reset, BCK_DIV=2, snd_l=16'hA5C3, snd_r=16'h0F01 strobed before the first slot 0:
  - bck period is 4 clk.
  - Slots 1..16 carry A5C3 MSB-first and slots 17..31 + next slot 0 carry 0F01.
  - LRCK is 0 on slots 0..15 and 1 on slots 16..31.
  - frame_req pulses once per 128 clk.
- No snd_vld for 3 frames after one sample: frames repeat the same data; urun_cnt = 3 (first frame counts as fresh).
- Two snd_vld in one frame (1234/5678, then 9ABC/DEF0): next frame transmits 9ABC/DEF0; orun_cnt = 1.
- snd_vld in the exact clk of the slot-0 load: current frame uses old pend; new sample is sent next frame; orun_cnt and urun_cnt unchanged.
- mute=1 at slot 0 with pend = 7FFF/8000: frame is all zeros. mute toggled mid-frame: no effect until the next slot 0.
- map_rst asserted at slot 20 for 1 clk:
  - Outputs go to 0.
  - Counters clear.
  - First falling event after release is slot 0.
  - Saturation: 300 underruns with CNT_W=8 → urun_cnt = 255.

Source files
------------

// File: rtl/mcd_dac_i2s_tx_pkg.sv
// Shared constants and sample type for the DacBus audio path towards the board DAC.
package mcd_dac_i2s_tx_pkg;

    localparam int DAC_BITS    = 16;
    localparam int FRAME_SLOTS = 32;
    localparam int SLOT_W      = $clog2(FRAME_SLOTS);
    localparam int FRAME_BITS  = 2 * DAC_BITS;

    typedef struct packed {
        logic signed [DAC_BITS-1:0] snd_l;
        logic signed [DAC_BITS-1:0] snd_r;
    } dac_sample_t;

    // Frame word as shifted out: left word in the upper half, MSB first.
    function automatic logic [FRAME_BITS-1:0] pack_frame(input dac_sample_t s, input logic mute);
        return mute ? '0 : {s.snd_l, s.snd_r};
    endfunction

endpackage

// File: rtl/mcd_dac_i2s_tx_if.sv
// DacBus sample input plus I2S pin bundle between mcd_core glue and the DAC transmitter.
interface mcd_dac_i2s_tx_if;
    import mcd_dac_i2s_tx_pkg::*;

    logic signed [DAC_BITS-1:0] snd_l;
    logic signed [DAC_BITS-1:0] snd_r;
    logic                       snd_vld;
    logic                       mute;
    logic                       i2s_bck;
    logic                       i2s_lrck;
    logic                       i2s_dat;
    logic                       frame_req;

    modport master (
        output snd_l, snd_r, snd_vld, mute,
        input  i2s_bck, i2s_lrck, i2s_dat, frame_req
    );

    modport slave (
        input  snd_l, snd_r, snd_vld, mute,
        output i2s_bck, i2s_lrck, i2s_dat, frame_req
    );

endinterface

// File: rtl/mcd_dac_bck_gen.sv
// Bit-clock divider and I2S slot counter; flags each BCK falling edge with its slot index.
module mcd_dac_bck_gen
    import mcd_dac_i2s_tx_pkg::*;
#(
    parameter int BCK_DIV = 16
) (
    input  logic              clk,
    input  logic              map_rst,
    output logic              fall_evt,
    output logic [SLOT_W-1:0] slot,
    output logic              bck
);

    localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             term;

    assign term     = (div_cnt == DIV_W'(BCK_DIV - 1));
    // slot holds the index of the falling edge about to happen, so slot 0 comes first after reset
    assign fall_evt = term && bck;

    always_ff @(posedge clk) begin
        if (map_rst) begin
            div_cnt <= '0;
            bck     <= 1'b0;
            slot    <= '0;
        end else begin
            if (term) begin
                div_cnt <= '0;
                bck     <= ~bck;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (fall_evt) begin
                slot <= slot + SLOT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mcd_dac_i2s_tx.sv
// I2S transmitter: one-frame holding register, 32-bit frame shifter and saturating diagnostics.
module mcd_dac_i2s_tx
    import mcd_dac_i2s_tx_pkg::*;
#(
    parameter int BCK_DIV = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             map_rst,
    mcd_dac_i2s_tx_if.slave  bus,
    output logic [CNT_W-1:0] urun_cnt,
    output logic [CNT_W-1:0] orun_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic                  fall_evt;
    logic [SLOT_W-1:0]     slot;
    logic                  bck;
    logic                  load;
    logic                  lrck;
    logic                  dat;
    logic                  req;
    logic                  pend_full;
    dac_sample_t           pend;
    logic [FRAME_BITS-1:0] sr;

    mcd_dac_bck_gen #(
        .BCK_DIV (BCK_DIV)
    ) u_bck_gen (
        .clk      (clk),
        .map_rst  (map_rst),
        .fall_evt (fall_evt),
        .slot     (slot),
        .bck      (bck)
    );

    assign load = fall_evt && (slot == '0);

    // Data leaves on BCK falling edges; sr[31] goes out one slot after LRCK changes (I2S delay).
    always_ff @(posedge clk) begin
        if (map_rst) begin
            lrck <= 1'b0;
            dat  <= 1'b0;
            req  <= 1'b0;
            sr   <= '0;
        end else begin
            req <= load;
            if (fall_evt) begin
                lrck <= (slot >= SLOT_W'(FRAME_SLOTS / 2));
                dat  <= sr[FRAME_BITS-1];
                if (load) begin
                    sr <= pack_frame(pend, bus.mute);
                end else begin
                    sr <= sr << 1;
                end
            end
        end
    end

    // A strobe coinciding with a load lands after the load has taken the old contents.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            pend      <= '0;
            pend_full <= 1'b0;
            urun_cnt  <= '0;
            orun_cnt  <= '0;
        end else begin
            if (bus.snd_vld) begin
                pend.snd_l <= bus.snd_l;
                pend.snd_r <= bus.snd_r;
                pend_full  <= 1'b1;
            end else if (load) begin
                pend_full <= 1'b0;
            end
            if (load && !pend_full) begin
                urun_cnt <= sat_inc(urun_cnt);
            end
            if (bus.snd_vld && pend_full && !load) begin
                orun_cnt <= sat_inc(orun_cnt);
            end
        end
    end

    assign bus.i2s_bck   = bck;
    assign bus.i2s_lrck  = lrck;
    assign bus.i2s_dat   = dat;
    assign bus.frame_req = req;

endmodule
